// File: rtl/sphincs_pkg.sv
// rtl/sphincs_pkg.sv - shared WOTS+ constants, ADRS offsets and chain FSM encoding
package sphincs_pkg;

  localparam int WOTS_W      = 16;
  localparam int WOTS_LOG_W  = 4;
  localparam int WOTS_LEN1   = 64;
  localparam int WOTS_LEN2   = 3;
  localparam int WOTS_LEN    = WOTS_LEN1 + WOTS_LEN2;
  localparam int N_BYTES     = 32;

  // Compressed ADRS layout: chain index and hash index byte positions.
  localparam int ADRS_CHAIN_OFF = 17;
  localparam int ADRS_HASH_OFF  = 21;
  localparam int ADRS_C_LEN     = 22;
  localparam int ADRS_C_BITS    = 8 * ADRS_C_LEN;

  localparam logic [6:0] SHA_LEN_F  = 7'd54;
  localparam logic [6:0] LAST_MSG   = 7'(WOTS_LEN1 - 1);
  localparam logic [6:0] LAST_CHAIN = 7'(WOTS_LEN - 1);
  localparam logic [3:0] LAST_STEP  = 4'(WOTS_W - 2);
  localparam logic [3:0] TOP_NIB    = 4'(WOTS_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BASEW = 3'd1,
    ST_LOAD  = 3'd2,
    ST_HREQ  = 3'd3,
    ST_HWAIT = 3'd4,
    ST_OUT   = 3'd5
  } wots_state_e;

endpackage

// File: rtl/wots_basew_csum.sv
// rtl/wots_basew_csum.sv - base-16 digest split, checksum chains and 67x4 start-index file
module wots_basew_csum
  import sphincs_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [255:0] msg_i,
  output logic         done_o,
  input  logic [6:0]   rd_idx_i,
  output logic [3:0]   rd_nib_o
);

  logic [255:0] msg_q, msg_d;
  logic [6:0]   cnt_q, cnt_d;
  logic         run_q, run_d;
  logic         csw_q, csw_d;
  logic [9:0]   csum_q, csum_d;
  logic         done_q, done_d;
  logic [3:0]   rf_q [WOTS_LEN];
  logic [3:0]   nib;
  logic [15:0]  c_word;

  // Current nibble is always the top of the shifting digest; 15-m equals ~m for 4 bits.
  assign nib      = msg_q[255:252];
  assign c_word   = {2'b00, csum_q, 4'h0};
  assign done_o   = done_q;
  assign rd_nib_o = rf_q[rd_idx_i];

  // Next-state: capture, 64 nibble cycles, one checksum write cycle, done pulse.
  always_comb begin
    msg_d  = msg_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    csw_d  = 1'b0;
    csum_d = csum_q;
    done_d = 1'b0;
    if (start_i && !run_q && !csw_q) begin
      msg_d  = msg_i;
      cnt_d  = 7'd0;
      run_d  = 1'b1;
      csum_d = 10'd0;
    end else if (run_q) begin
      msg_d  = {msg_q[251:0], 4'h0};
      csum_d = csum_q + {6'b0, ~nib};
      cnt_d  = cnt_q + 7'd1;
      if (cnt_q == LAST_MSG) begin
        run_d = 1'b0;
        csw_d = 1'b1;
      end
    end else if (csw_q) begin
      done_d = 1'b1;
    end
  end

  // Control and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      csw_q  <= 1'b0;
      csum_q <= '0;
      done_q <= 1'b0;
    end else begin
      msg_q  <= msg_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      csw_q  <= csw_d;
      csum_q <= csum_d;
      done_q <= done_d;
    end
  end

  // Start-index file: message nibbles while running, checksum nibbles in the final cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < WOTS_LEN; k++) rf_q[k] <= 4'h0;
    end else if (run_q) begin
      rf_q[cnt_q] <= nib;
    end else if (csw_q) begin
      rf_q[WOTS_LEN1]     <= c_word[15:12];
      rf_q[WOTS_LEN1 + 1] <= c_word[11:8];
      rf_q[WOTS_LEN1 + 2] <= c_word[7:4];
    end
  end

endmodule

// File: rtl/wots_pk_from_sig.sv
// rtl/wots_pk_from_sig.sv - WOTS+ public key recovery: walk each signature chain to w-1
module wots_pk_from_sig
  import sphincs_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] msg,
  input  logic [255:0] wots_addr,
  input  logic         sig_vld,
  output logic         sig_rdy,
  input  logic [255:0] sig_din,
  output logic         sha256_start,
  output logic         sha256_1st,
  output logic         sha256_seed,
  output logic         sha256_final,
  output logic [255:0] sha256_state,
  output logic [511:0] sha256_data,
  output logic [6:0]   sha256_len,
  input  logic         sha256_done,
  input  logic [255:0] sha256_dout,
  output logic         pk_vld,
  input  logic         pk_rdy,
  output logic [6:0]   pk_idx,
  output logic [255:0] pk_dout,
  output logic         busy,
  output logic         done
);

  wots_state_e state_q, state_d;
  logic [6:0]   i_q, i_d;
  logic [3:0]   j_q, j_d;
  logic [255:0] x_q, x_d;
  logic [ADRS_C_BITS-1:0] addr_q, addr_d;
  logic         done_q, done_d;
  logic         bw_start, bw_done;
  logic [3:0]   m_i;
  logic [ADRS_C_BITS-1:0] addr_c;
  logic         unused_addr_tail;

  // Only the compressed 22-byte ADRS prefix enters the F block.
  assign unused_addr_tail = ^wots_addr[255-ADRS_C_BITS:0];
  assign bw_start         = (state_q == ST_IDLE) && start;

  wots_basew_csum u_basew (
    .clk      (clk),
    .rst      (rst),
    .start_i  (bw_start),
    .msg_i    (msg),
    .done_o   (bw_done),
    .rd_idx_i (i_q),
    .rd_nib_o (m_i)
  );

  // Chain FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Chain FSM next-state: load chunk, hash until step 14 done, emit, repeat for 67 chains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_BASEW;
      ST_BASEW: if (bw_done) state_d = ST_LOAD;
      ST_LOAD:  if (sig_vld) state_d = (m_i == TOP_NIB) ? ST_OUT : ST_HREQ;
      ST_HREQ:  state_d = ST_HWAIT;
      ST_HWAIT: if (sha256_done) state_d = (j_q == LAST_STEP) ? ST_OUT : ST_HREQ;
      ST_OUT:   if (pk_rdy) state_d = (i_q == LAST_CHAIN) ? ST_IDLE : ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: chain value x, step j, chain index i, captured ADRS.
  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    x_d    = x_q;
    addr_d = addr_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        addr_d = wots_addr[255 -: ADRS_C_BITS];
        i_d    = 7'd0;
      end
      ST_LOAD: if (sig_vld) begin
        x_d = sig_din;
        j_d = m_i;
      end
      ST_HWAIT: if (sha256_done) begin
        x_d = sha256_dout;
        j_d = j_q + 4'd1;
      end
      ST_OUT: if (pk_rdy) begin
        if (i_q == LAST_CHAIN) done_d = 1'b1;
        else                   i_d = i_q + 7'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q    <= '0;
      j_q    <= '0;
      x_q    <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      x_q    <= x_d;
      addr_q <= addr_d;
      done_q <= done_d;
    end
  end

  // ADRS with chain index and hash index substituted for the current F call.
  always_comb begin
    addr_c = addr_q;
    addr_c[ADRS_C_BITS-1-8*ADRS_CHAIN_OFF -: 8] = {1'b0, i_q};
    addr_c[ADRS_C_BITS-1-8*ADRS_HASH_OFF -: 8]  = {4'h0, j_q};
  end

  // Chain FSM outputs: request fields are only driven while a request is issued.
  always_comb begin
    sig_rdy      = 1'b0;
    sha256_start = 1'b0;
    sha256_seed  = 1'b0;
    sha256_final = 1'b0;
    sha256_len   = 7'd0;
    sha256_data  = '0;
    pk_vld       = 1'b0;
    pk_idx       = 7'd0;
    pk_dout      = '0;
    case (state_q)
      ST_LOAD: sig_rdy = 1'b1;
      ST_HREQ: begin
        sha256_start = 1'b1;
        sha256_seed  = 1'b1;
        sha256_final = 1'b1;
        sha256_len   = SHA_LEN_F;
        sha256_data  = {addr_c, x_q, 80'h0};
      end
      ST_OUT: begin
        pk_vld  = 1'b1;
        pk_idx  = i_q;
        pk_dout = x_q;
      end
      default: ;
    endcase
  end

  assign sha256_1st   = 1'b0;
  assign sha256_state = '0;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_wots_pk_from_sig.sv
// tb/tb_wots_pk_from_sig.sv - self-checking bench for wots_pk_from_sig
module tb_wots_pk_from_sig;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] msg;
  logic [255:0] wots_addr;
  logic         sig_vld;
  logic         sig_rdy;
  logic [255:0] sig_din;
  logic         sha256_start, sha256_1st, sha256_seed, sha256_final;
  logic [255:0] sha256_state;
  logic [511:0] sha256_data;
  logic [6:0]   sha256_len;
  logic         sha256_done;
  logic [255:0] sha256_dout;
  logic         pk_vld;
  logic         pk_rdy;
  logic [6:0]   pk_idx;
  logic [255:0] pk_dout;
  logic         busy, done;

  always #5 clk = ~clk;

  wots_pk_from_sig dut (
    .clk(clk), .rst(rst), .start(start), .msg(msg), .wots_addr(wots_addr),
    .sig_vld(sig_vld), .sig_rdy(sig_rdy), .sig_din(sig_din),
    .sha256_start(sha256_start), .sha256_1st(sha256_1st), .sha256_seed(sha256_seed),
    .sha256_final(sha256_final), .sha256_state(sha256_state), .sha256_data(sha256_data),
    .sha256_len(sha256_len), .sha256_done(sha256_done), .sha256_dout(sha256_dout),
    .pk_vld(pk_vld), .pk_rdy(pk_rdy), .pk_idx(pk_idx), .pk_dout(pk_dout),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [255:0] msg;
    bit           use_tab;
    int           m64, m65, m66;
    int           exp_total;
    bit           sig_rand;
    int           stall;
    bit           restart;
    bit           chk5;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] sig_mem [67];
  int           m_ref [67];
  logic [255:0] pk_ref [67];

  int  call_cnt [67];
  int  first_b21 [67];
  int  last_b21 [67];
  int  req_total;
  int  lat_max = 3;
  int  lat_fix = -1;
  bit  pend = 1'b0;
  int  cd;
  logic [255:0] resp;

  int  sig_acc;
  int  done_cnt;
  int  stall_idx = -1;
  int  stall_cnt;
  bit  sig_rand;
  bit  drv_en = 1'b0;
  int  pk_idx_q[$];
  logic [255:0] pk_dout_q[$];

  task automatic check(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stand-in for the SHA-256 compression result: any fixed mixing function of the block.
  function automatic logic [255:0] mix(input logic [511:0] d);
    logic [255:0] a, b;
    a = d[511:256];
    b = d[255:0];
    return (a ^ {b[242:0], b[255:243]}) + {8{32'h9e3779b9}};
  endfunction

  // Reference: base-w digits, checksum digits, then chains built byte by byte.
  task automatic build_model(input logic [255:0] mg, input logic [255:0] ad);
    int csum;
    logic [255:0] t, x;
    logic [7:0] b [64];
    logic [511:0] blk;
    csum = 0;
    for (int i = 0; i < 64; i++) begin
      t = mg >> (252 - 4 * i);
      m_ref[i] = int'(t[3:0]);
      csum += 15 - m_ref[i];
    end
    m_ref[64] = (csum >> 8) & 15;
    m_ref[65] = (csum >> 4) & 15;
    m_ref[66] = csum & 15;
    for (int i = 0; i < 67; i++) begin
      x = sig_mem[i];
      for (int j = m_ref[i]; j < 15; j++) begin
        for (int k = 0; k < 64; k++) b[k] = 8'h00;
        for (int k = 0; k < 22; k++) b[k] = ad[255 - 8 * k -: 8];
        b[17] = 8'(i);
        b[21] = 8'(j);
        for (int k = 0; k < 32; k++) b[22 + k] = x[255 - 8 * k -: 8];
        for (int k = 0; k < 64; k++) blk[511 - 8 * k -: 8] = b[k];
        x = mix(blk);
      end
      pk_ref[i] = x;
    end
  endtask

  // SHA core emulator: variable latency, one result per request, checks request fields.
  initial begin
    sha256_done = 1'b0;
    sha256_dout = '0;
    forever begin
      @(negedge clk);
      sha256_done = 1'b0;
      if (pend) begin
        if (cd == 0) begin
          sha256_done = 1'b1;
          sha256_dout = resp;
          pend = 1'b0;
        end else begin
          cd--;
        end
      end
      if (sha256_start) begin
        int b17, b21;
        check(!pend, "one_outstanding", 256'(pend), 256'(0));
        check({sha256_1st, sha256_seed, sha256_final, sha256_len} == {1'b0, 1'b1, 1'b1, 7'd54},
              "req_ctrl", 256'({sha256_1st, sha256_seed, sha256_final, sha256_len}),
              256'({1'b0, 1'b1, 1'b1, 7'd54}));
        b17 = int'(sha256_data[375:368]);
        b21 = int'(sha256_data[343:336]);
        if (b17 < 67) begin
          if (call_cnt[b17] == 0) first_b21[b17] = b21;
          last_b21[b17] = b21;
          call_cnt[b17]++;
        end
        req_total++;
        pend = 1'b1;
        cd   = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, lat_max));
        resp = mix(sha256_data);
      end
    end
  end

  // Output monitor: pk accept log, hold stability under backpressure, chunk and done counts.
  initial begin
    bit held;
    int h_idx;
    logic [255:0] h_dout;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (pk_vld) begin
          if (held) check({pk_idx, pk_dout} == {7'(h_idx), h_dout}, "pk_stable",
                          256'(pk_idx) ^ pk_dout, 256'(h_idx) ^ h_dout);
          if (pk_rdy) begin
            pk_idx_q.push_back(int'(pk_idx));
            pk_dout_q.push_back(pk_dout);
            held = 1'b0;
          end else begin
            held   = 1'b1;
            h_idx  = int'(pk_idx);
            h_dout = pk_dout;
          end
        end else begin
          held = 1'b0;
        end
        if (sig_vld && sig_rdy) sig_acc++;
        if (done) done_cnt++;
      end
    end
  end

  // Stream driver: signature chunks in order, optional random valid, pk stall at one index.
  initial begin
    sig_vld = 1'b0;
    sig_din = '0;
    pk_rdy  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (drv_en) begin
        sig_vld = sig_rand ? 1'($urandom % 2) : 1'b1;
        sig_din = sig_mem[(sig_acc < 67) ? sig_acc : 66];
        if (pk_vld && int'(pk_idx) == stall_idx && stall_cnt < 10) begin
          pk_rdy = 1'b0;
          stall_cnt++;
        end else begin
          pk_rdy = 1'b1;
        end
      end else begin
        sig_vld = 1'b0;
        pk_rdy  = 1'b0;
      end
    end
  end

  task automatic clear_run();
    for (int i = 0; i < 67; i++) begin
      call_cnt[i]  = 0;
      first_b21[i] = -1;
      last_b21[i]  = -1;
    end
    req_total = 0;
    pk_idx_q.delete();
    pk_dout_q.delete();
    done_cnt  = 0;
    sig_acc   = 0;
    stall_cnt = 0;
  endtask

  task automatic pulse_start(input logic [255:0] mg, input logic [255:0] ad);
    @(posedge clk);
    #1;
    start     = 1'b1;
    msg       = mg;
    wots_addr = ad;
    @(posedge clk);
    #1;
    start     = 1'b0;
    msg       = ~mg;
    wots_addr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_vector(input vec_t v);
    logic [255:0] ad;
    int cyc, tot;
    clear_run();
    stall_idx = v.stall;
    sig_rand  = v.sig_rand;
    ad = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 67; i++)
      for (int w = 0; w < 8; w++) sig_mem[i][32 * w +: 32] = $urandom;
    build_model(v.msg, ad);
    drv_en = 1'b1;
    pulse_start(v.msg, ad);
    if (v.restart) begin
      repeat (5) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check(done_cnt > 0, "done_timeout", 256'(cyc), 256'(0));
    repeat (4) @(negedge clk);
    check(done_cnt == 1, "done_once", 256'(done_cnt), 256'(1));
    check(!busy, "busy_after_done", 256'(busy), 256'(0));
    check(pk_idx_q.size() == 67, "pk_count", 256'(pk_idx_q.size()), 256'(67));
    check(sig_acc == 67, "sig_chunks", 256'(sig_acc), 256'(67));
    for (int k = 0; k < pk_idx_q.size() && k < 67; k++) begin
      check(pk_idx_q[k] == k, "pk_idx_order", 256'(pk_idx_q[k]), 256'(k));
      check(pk_dout_q[k] == pk_ref[k], "pk_value", pk_dout_q[k], pk_ref[k]);
    end
    tot = 0;
    for (int i = 0; i < 67; i++) begin
      check(call_cnt[i] == 15 - m_ref[i], "chain_calls", 256'(call_cnt[i]), 256'(15 - m_ref[i]));
      tot += call_cnt[i];
    end
    if (v.use_tab) begin
      check(tot == v.exp_total, "total_calls", 256'(tot), 256'(v.exp_total));
      check(call_cnt[64] == 15 - v.m64, "csum_chain64", 256'(call_cnt[64]), 256'(15 - v.m64));
      check(call_cnt[65] == 15 - v.m65, "csum_chain65", 256'(call_cnt[65]), 256'(15 - v.m65));
      check(call_cnt[66] == 15 - v.m66, "csum_chain66", 256'(call_cnt[66]), 256'(15 - v.m66));
    end
    if (v.chk5) begin
      check(first_b21[5] == 'h0A, "chain5_first_hash", 256'(first_b21[5]), 256'('h0A));
      check(last_b21[5] == 'h0E, "chain5_last_hash", 256'(last_b21[5]), 256'('h0E));
    end
    drv_en = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  vec_t vecs [4];

  initial begin
    logic [255:0] r;
    int cyc, loud;

    vecs[0] = '{msg: '0, use_tab: 1, m64: 3, m65: 12, m66: 0, exp_total: 990,
                sig_rand: 0, stall: -1, restart: 0, chk5: 0};
    vecs[1] = '{msg: {256{1'b1}}, use_tab: 1, m64: 0, m65: 0, m66: 0, exp_total: 45,
                sig_rand: 0, stall: -1, restart: 0, chk5: 0};
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    r[235:232] = 4'hA;
    vecs[2] = '{msg: r, use_tab: 0, m64: 0, m65: 0, m66: 0, exp_total: 0,
                sig_rand: 0, stall: -1, restart: 0, chk5: 1};
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    vecs[3] = '{msg: r, use_tab: 0, m64: 0, m65: 0, m66: 0, exp_total: 0,
                sig_rand: 1, stall: 3, restart: 1, chk5: 0};

    rst       = 1'b1;
    start     = 1'b0;
    msg       = '0;
    wots_addr = '0;
    repeat (3) @(negedge clk);
    check({busy, done, sig_rdy, pk_vld, sha256_start, sha256_seed, sha256_final, sha256_1st} == 8'h00,
          "reset_ctrl", 256'({busy, done, sig_rdy, pk_vld, sha256_start, sha256_seed, sha256_final, sha256_1st}),
          256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check((sha256_data | sha256_state | pk_dout) == '0 && pk_idx == 7'd0 && sha256_len == 7'd0 && !busy,
          "reset_data", sha256_data[511:256] | pk_dout, 256'(0));

    for (int t = 0; t < 4; t++) run_vector(vecs[t]);

    // Reset while a hash is in flight, followed by a late result from the core.
    clear_run();
    sig_rand  = 1'b0;
    stall_idx = -1;
    for (int i = 0; i < 67; i++) sig_mem[i] = {8{$urandom}};
    lat_fix = 8;
    drv_en  = 1'b1;
    pulse_start('0, {8{$urandom}});
    cyc = 0;
    while (req_total == 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check(req_total > 0, "first_req_timeout", 256'(cyc), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    loud = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (busy || done || sig_rdy || pk_vld || sha256_start || pk_dout != '0 || sha256_data != '0) loud++;
    end
    check(loud == 0, "idle_after_rst", 256'(loud), 256'(0));
    drv_en  = 1'b0;
    lat_fix = -1;
    repeat (2) @(posedge clk);

    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_vector('{msg: r, use_tab: 0, m64: 0, m65: 0, m66: 0, exp_total: 0,
                 sig_rand: 1, stall: -1, restart: 0, chk5: 0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wots_pk_from_sig.md
Name: wots_pk_from_sig

Overview:
Verify-side counterpart of the WOTS signing engine: recovers a WOTS+ public key from a 67-chunk WOTS signature and a 256-bit message digest.
- For each chain i it runs F (one SHA-256 block via the shared sha256 core, pub_seed pre-state) from start index m_i up to w-1.
- It emits the 67 chain-end values in order to the downstream pk compressor (thash, outside this block).
- Parameter set: n=32 bytes, w=16, len1=64, len2=3.

Parameters:
- WOTS_LEN1, 64, message chains
- WOTS_LEN2, 3, checksum chains
- WOTS_W, 16, Winternitz parameter (only 16 supported; lg_w=4)
- SHA_LEN_F, 54, byte length of an F block (22-byte compressed addr + 32-byte value)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle pulse; begin recovery; ignored while busy
- msg  in  256  digest to be converted to base-w; sampled at start
- wots_addr  in  256  ADRS, WOTS_HASH type; byte k = wots_addr[255-8k -: 8]; sampled at start
- sig_vld  in  1  signature chunk valid
- sig_rdy  out  1  signature chunk accepted when sig_vld&sig_rdy
- sig_din  in  256  signature chunk i (chunks 0..66 in order)
- sha256_start  out  1  single-cycle request to the sha256 core
- sha256_1st  out  1  always 0
- sha256_seed  out  1  always 1 during a request (core uses the pub_seed pre-state)
- sha256_final  out  1  always 1
- sha256_state  out  256  always 0
- sha256_data  out  512  F block
- sha256_len  out  7  SHA_LEN_F (54)
- sha256_done  in  1  core result valid, one cycle
- sha256_dout  in  256  core result
- pk_vld  out  1  chain-end value valid
- pk_rdy  in  1  downstream accepts when pk_vld&pk_rdy
- pk_idx  out  7  chain index 0..66
- pk_dout  out  256  chain-end value
- busy  out  1  high from accepted start until done
- done  out  1  single-cycle pulse after pk 66 accepted

Behaviour:
Reset values: all outputs 0; FSM in IDLE; all counters 0. An asserted rst mid-operation aborts immediately; any sha256_done arriving after rst release is ignored.

IDLE:
- start captures msg and wots_addr, clears csum, sets busy, goes to BASEW.

BASEW: one nibble per cycle for 64 cycles.
- m_i = msg[255-4i -: 4], so high nibble of each byte comes first.
- Store m_i into a 67x4 register file.
- csum += 15 - m_i (10-bit accumulator, max 960).
- Then CSUMW: c = {csum,4'b0} (16 bits); m_64 = c[15:12], m_65 = c[11:8], m_66 = c[7:4]. Takes 1 cycle. Go to LOAD with i=0.

LOAD:
- sig_rdy=1. On handshake: x <= sig_din, j <= m_i.
- If m_i==15, go to OUT; else go to HREQ.

HREQ (1 cycle):
- Assert sha256_start.
- sha256_data = {addr_c, x, 80'h0}, where addr_c = wots_addr bytes 0..21 with byte 17 replaced by i and byte 21 replaced by j.
- Go to HWAIT.

HWAIT:
- On sha256_done: x <= sha256_dout, j <= j+1.
- If j==14 (last step), go to OUT; else go to HREQ.
- sha256_done outside HWAIT is ignored.

OUT:
- pk_vld=1, pk_idx=i, pk_dout=x, held stable until pk_rdy.
- On accept: if i==66, pulse done, clear busy, go to IDLE; else i++ and go to LOAD.

Rules:
- The F call count for chain i is exactly 15-m_i.
- sig_rdy is high only in LOAD.
- Exactly one sha256 request is outstanding at a time.
- Throughput per F call is 1 + core latency cycles.

Decomposition:
- Shared package sphincs_pkg holds: WOTS_W, WOTS_LEN1, WOTS_LEN2, WOTS_LEN=67, N_BYTES=32, ADRS byte offsets (CHAIN=17, HASH=21, compressed length 22), SHA_LEN_F, and FSM state encodings.
- One natural sub-module: wots_basew_csum. It contains the sequential nibble extractor, the checksum accumulator and the 67x4 register file. It has start/done handshake and an index read port.
- The top module holds the chain FSM, the sha256 request formatting and both stream handshakes.

Test Plan:
- msg=0, sig chunks = random, immediate pk_rdy:
  - m_0..63=0, csum=960=0x3C0, c=0x3C00, so m_64..66 = 3, 12, 0.
  - F-call counts per chain: 15×64, then 12, 3, 15; 990 total.
  - pk values match a C reference model; done fires once.
- msg=all 0xFF:
  - csum=0, so m_64..66=0.
  - pk 0..63 equal sig chunks unchanged, with no sha256_start for them.
  - Chains 64..66 take 15 calls each (45 total).
- msg with nibble 5 = 0xA:
  - The first F request for chain 5 has data byte 17 = 0x05 and byte 21 = 0x0A.
  - The last request for chain 5 has byte 21 = 0x0E.
  - sha256_len=54, seed=1, final=1, 1st=0.
- Backpressure:
  - sig_vld toggled randomly and pk_rdy held low for 10 cycles at pk_idx 3.
  - pk_dout and pk_idx stay stable while low; no chunk is lost or duplicated; order is 0..66.
- Reset and stray events:
  - start pulsed again while busy: ignored.
  - rst asserted while in HWAIT, then a stale sha256_done: outputs return to 0 and the block stays in IDLE.
  - A fresh start then completes correctly.
